// File: rtl/mdr_mem_if.sv
// Memory data register with a request/acknowledge memory engine.
// Handles byte/half/full accesses with lane extraction, extension, replication and a wait timeout.
module mdr_mem_if #(
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 15,
   localparam int NB        = DATA_WIDTH / 8,
   localparam int OW        = $clog2(NB)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  mdr_in,
   input  logic [DATA_WIDTH-1:0] bus_mux_out,
   input  logic                  mem_read,
   input  logic                  mem_write,
   input  logic [1:0]            size,
   input  logic                  sign_ext,
   input  logic [OW-1:0]         addr_ofs,
   input  logic [DATA_WIDTH-1:0] m_data_in,
   input  logic                  m_ack,
   output logic                  m_req,
   output logic                  m_we,
   output logic [NB-1:0]         m_be,
   output logic [DATA_WIDTH-1:0] m_data_out,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [DATA_WIDTH-1:0] mdr_output
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RD   = 2'd1;
   localparam logic [1:0] WR   = 2'd2;

   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

   localparam logic [NB-1:0]         ONE_LANE  = NB'(1);
   localparam logic [NB-1:0]         TWO_LANE  = NB'(3);
   localparam logic [DATA_WIDTH-1:0] BYTE_MASK = DATA_WIDTH'(8'hFF);
   localparam logic [DATA_WIDTH-1:0] HALF_MASK = DATA_WIDTH'(16'hFFFF);

   logic [1:0]            state;
   logic [DATA_WIDTH-1:0] mdr;
   logic [1:0]            lat_size;
   logic                  lat_sext;
   logic [OW-1:0]         lat_ofs;
   logic [CW-1:0]         wait_cnt;

   logic                  start;
   logic                  reject;
   logic [NB-1:0]         start_be;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [DATA_WIDTH-1:0] rd_shift;
   logic [DATA_WIDTH-1:0] rd_val;

   assign busy       = (state != IDLE);
   assign mdr_output = mdr;
   assign start      = mem_read | mem_write;

   assign reject = (mem_read & mem_write)
                 | (size == 2'b11)
                 | ((size == 2'b01) & addr_ofs[0])
                 | ((size == 2'b10) & (addr_ofs != '0));

   always_comb begin
      start_be = '1;
      wr_data  = mdr;
      case (size)
         2'b00: begin
            start_be = ONE_LANE << addr_ofs;
            wr_data  = {NB{mdr[7:0]}};
         end
         2'b01: begin
            start_be = TWO_LANE << addr_ofs;
            wr_data  = {(DATA_WIDTH/16){mdr[15:0]}};
         end
         default: begin
            start_be = '1;
            wr_data  = mdr;
         end
      endcase
   end

   // Shift the addressed lane down to bit 0, then mask and fill the upper bits
   assign rd_shift = m_data_in >> {lat_ofs, 3'b000};

   always_comb begin
      rd_val = rd_shift;
      case (lat_size)
         2'b00:   rd_val = (rd_shift & BYTE_MASK)
                         | ({DATA_WIDTH{lat_sext & rd_shift[7]}} & ~BYTE_MASK);
         2'b01:   rd_val = (rd_shift & HALF_MASK)
                         | ({DATA_WIDTH{lat_sext & rd_shift[15]}} & ~HALF_MASK);
         default: rd_val = rd_shift;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         mdr        <= '0;
         lat_size   <= '0;
         lat_sext   <= 1'b0;
         lat_ofs    <= '0;
         wait_cnt   <= '0;
         m_req      <= 1'b0;
         m_we       <= 1'b0;
         m_be       <= '0;
         m_data_out <= '0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (reject) begin
                     err <= 1'b1;
                  end else begin
                     state      <= mem_write ? WR : RD;
                     lat_size   <= size;
                     lat_sext   <= sign_ext;
                     lat_ofs    <= addr_ofs;
                     wait_cnt   <= '0;
                     m_req      <= 1'b1;
                     m_we       <= mem_write;
                     m_be       <= start_be;
                     m_data_out <= mem_write ? wr_data : '0;
                  end
               end else if (mdr_in) begin
                  mdr <= bus_mux_out;
               end
            end
            RD, WR: begin
               // Acknowledge in the final permitted cycle still completes normally
               if (m_ack || (wait_cnt == LAST_WAIT)) begin
                  state      <= IDLE;
                  m_req      <= 1'b0;
                  m_we       <= 1'b0;
                  m_be       <= '0;
                  m_data_out <= '0;
                  if (m_ack) begin
                     done <= 1'b1;
                     if (state == RD) mdr <= rd_val;
                  end else begin
                     err <= 1'b1;
                  end
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/mdr_mem_if.md
# mdr_mem_if

Parametrised memory data register with an integrated memory handshake engine. It holds the datapath MDR and loads it from the internal bus or from memory. It runs request/acknowledge read and write transactions with byte, half-word and full-width access sizes. Reads are lane-extracted and sign- or zero-extended; writes are lane-replicated with byte enables. A bounded wait timeout aborts a transaction that is never acknowledged. It sits between the bus multiplexer and the external memory port, under control-unit sequencing.

## Interface
- DATA_WIDTH, 32, MDR and memory data width; multiple of 16, minimum 16.
- TIMEOUT, 15, maximum cycles m_req is held without m_ack before abort; minimum 1.
- Derived: NB = DATA_WIDTH/8 (byte lanes); OW = clog2(NB) (offset width).

- clk, input, 1, single clock, rising edge.
- reset, input, 1, asynchronous, active-high.
- mdr_in, input, 1, load bus_mux_out into MDR (IDLE only).
- bus_mux_out, input, DATA_WIDTH, internal bus value.
- mem_read, input, 1, start read transaction (1-cycle strobe).
- mem_write, input, 1, start write of MDR (1-cycle strobe).
- size, input, 2, 00 byte, 01 half, 10 full width, 11 reserved.
- sign_ext, input, 1, reads: 1 sign-extend, 0 zero-extend.
- addr_ofs, input, OW, byte offset within the memory word.
- m_data_in, input, DATA_WIDTH, memory read data, valid with m_ack.
- m_ack, input, 1, memory acknowledge.
- m_req, output, 1, memory request, registered.
- m_we, output, 1, 1 = write, registered.
- m_be, output, NB, byte enables, registered.
- m_data_out, output, DATA_WIDTH, write data, registered.
- busy, output, 1, transaction in progress.
- done, output, 1, one-cycle pulse on successful completion.
- err, output, 1, one-cycle pulse on rejected or aborted transaction.
- mdr_output, output, DATA_WIDTH, MDR contents.

## Operation
- States: IDLE, RD, WR. Reset forces IDLE; all outputs and MDR go to 0.
- IDLE:
  - mdr_in=1 with no start loads bus_mux_out into MDR.
  - A start (mem_read or mem_write) takes priority; mdr_in is ignored that cycle.
  - Size, sign_ext and addr_ofs are latched at start and held until the transaction ends.
- Start is rejected with an err pulse, no m_req, and MDR unchanged when:
  - mem_read and mem_write are both asserted, or
  - size=11, or
  - the access is misaligned: half with addr_ofs[0]=1, or full width with addr_ofs≠0.
- RD:
  - m_req=1, m_we=0, m_be = lanes covered by the access.
  - On m_ack, MDR takes the extracted field (byte: m_data_in[8·ofs+:8]; half: m_data_in[8·ofs+:16]), extended to DATA_WIDTH per sign_ext, or full m_data_in.
  - Then go to IDLE.
- WR:
  - m_req=1, m_we=1.
  - m_data_out: byte → MDR[7:0] replicated across all lanes; half → MDR[15:0] replicated; full → MDR.
  - m_be: byte → one-hot at ofs; half → 2'b11 << ofs; full → all ones.
  - On m_ack, go to IDLE; MDR unchanged.
- Timeout:
  - A wait counter clears on entering RD/WR and increments each cycle without m_ack.
  - When no m_ack arrives in the TIMEOUT-th request cycle, abort: go to IDLE, pulse err, MDR unchanged.
  - m_ack in that final cycle completes normally; acknowledge wins over timeout.
- Strobes: mem_read, mem_write and mdr_in are ignored while busy. m_ack is ignored in IDLE.
- busy = (state≠IDLE).

## Timing
- Start sampled at edge E0. m_req, m_we, m_be and m_data_out are valid from E0 and stable until the ending edge.
- m_ack sampled at edge Ek (k≥1). MDR is updated at Ek. From Ek, m_req=0, busy=0 and done=1 for one cycle.
- Minimum start-to-done is 2 edges (ack in first request cycle). A new start is accepted in the cycle done is high.
- Abort: m_req is high for exactly TIMEOUT cycles; err is high the following cycle.
- Reject: err is high for one cycle after the start edge; busy stays 0.
- Reset mid-transaction: m_req drops immediately (asynchronous), state goes IDLE, MDR=0, no done or err.

## Test plan
- Reset → mdr_output=0, m_req=0, busy=0. mdr_in=1, bus_mux_out=0xDEADBEEF → mdr_output=0xDEADBEEF next cycle.
- Read byte, ofs=2, sign_ext=1, m_data_in=0x1280_3456, ack after 3 cycles → m_be=0100, MDR=0xFFFFFF80, done 1 cycle, m_req high 3 cycles. Repeat with sign_ext=0 → 0x00000080.
- Write half, ofs=2, MDR=0x0000ABCD, immediate ack → m_we=1, m_be=1100, m_data_out=0xABCDABCD, done at 2nd edge.
- Misaligned full read (ofs=1), size=11, and mem_read with mem_write → err pulse each time, m_req never asserted, MDR unchanged.
- No ack, TIMEOUT=15 → m_req high exactly 15 cycles, then err, MDR unchanged. Ack in 15th cycle → done, not err.
- Reset asserted mid-RD → m_req drops same cycle, MDR=0. Then mdr_in in the same cycle as mem_read → read proceeds, bus value is not loaded.
